// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state type and index-width helper for the SRAM wrapper
package sram_pkg;
  typedef enum logic {INIT, IDLE} state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/sram_array_1p.sv
// sram_array_1p: behavioural single-port SETSxWAYSxWIDTH array with per-way write mask
module sram_array_1p #(
  parameter int SETS  = 64,
  parameter int WAYS  = 8,
  parameter int WIDTH = 6,
  parameter int IDXW  = 6
) (
  input  logic                  RW0_clk,
  input  logic [IDXW-1:0]       RW0_addr,
  input  logic                  RW0_en,
  input  logic                  RW0_wmode,
  input  logic [WAYS*WIDTH-1:0] RW0_wdata,
  input  logic [WAYS-1:0]       RW0_wmask,
  output logic [WAYS*WIDTH-1:0] RW0_rdata
);
  logic [WAYS*WIDTH-1:0] mem [SETS];
  // Read data is registered, matching the macro's one-cycle read latency
  always_ff @(posedge RW0_clk) begin
    if (RW0_en && RW0_wmode)
      for (int i = 0; i < WAYS; i++)
        if (RW0_wmask[i]) mem[RW0_addr][i*WIDTH +: WIDTH] <= RW0_wdata[i*WIDTH +: WIDTH];
    if (RW0_en && !RW0_wmode) RW0_rdata <= mem[RW0_addr];
  end
endmodule

// File: rtl/sram_template_ext.sv
// sram_template_ext: set-associative SRAM wrapper with zeroing sweep, ready/valid
// handshakes, read-response valid and optional hold-read output register.
module sram_template_ext
  import sram_pkg::*;
#(
  parameter int SETS         = 64,
  parameter int WAYS         = 8,
  parameter int WIDTH        = 6,
  parameter bit HOLD_READ    = 1,
  parameter bit SHOULD_RESET = 1,
  localparam int IDXW        = clog2(SETS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  io_rreq_valid,
  output logic                  io_rreq_ready,
  input  logic [IDXW-1:0]       io_rreq_bits_setIdx,
  output logic                  io_rresp_valid,
  output logic [WAYS*WIDTH-1:0] io_rresp_data,
  input  logic                  io_wreq_valid,
  output logic                  io_wreq_ready,
  input  logic [IDXW-1:0]       io_wreq_bits_setIdx,
  input  logic [WAYS*WIDTH-1:0] io_wreq_bits_data,
  input  logic [WAYS-1:0]       io_wreq_bits_waymask,
  output logic                  io_init_done
);
  localparam int DW = WAYS * WIDTH;
  state_e          state_q;
  logic [IDXW-1:0] init_cnt_q;
  logic            rresp_valid_q;
  logic            init_done_q;
  logic            in_init;
  logic            write_fire;
  logic            read_fire;
  logic [DW-1:0]   rdata;
  assign in_init       = state_q == INIT;
  // Readiness is gated by reset so nothing is accepted while the block is held
  assign io_wreq_ready = reset_n && !in_init;
  assign io_rreq_ready = reset_n && !in_init && !io_wreq_valid;
  assign write_fire    = io_wreq_valid && io_wreq_ready;
  assign read_fire     = io_rreq_valid && io_rreq_ready;
  sram_array_1p #(
    .SETS (SETS),
    .WAYS (WAYS),
    .WIDTH(WIDTH),
    .IDXW (IDXW)
  ) u_array (
    .RW0_clk  (clock),
    .RW0_addr (in_init ? init_cnt_q : (io_wreq_valid ? io_wreq_bits_setIdx : io_rreq_bits_setIdx)),
    .RW0_en   (write_fire || read_fire || in_init),
    .RW0_wmode(write_fire || in_init),
    .RW0_wdata(in_init ? '0 : io_wreq_bits_data),
    .RW0_wmask(in_init ? '1 : io_wreq_bits_waymask),
    .RW0_rdata(rdata)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SHOULD_RESET ? INIT : IDLE;
      init_cnt_q    <= '0;
      rresp_valid_q <= 1'b0;
      init_done_q   <= 1'b0;
    end else begin
      rresp_valid_q <= read_fire;
      if (in_init) begin
        if (init_cnt_q == IDXW'(SETS - 1)) begin
          state_q     <= IDLE;
          init_done_q <= 1'b1;
        end else begin
          init_cnt_q <= init_cnt_q + 1'b1;
        end
      end else begin
        init_done_q <= 1'b1;
      end
    end
  end
  assign io_rresp_valid = rresp_valid_q;
  assign io_init_done   = init_done_q;
  generate
    if (HOLD_READ) begin : g_hold
      logic [DW-1:0] hold_q;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) hold_q <= '0;
        else if (rresp_valid_q) hold_q <= rdata;
      end
      // Fresh data is forwarded in the response cycle, the held copy afterwards
      assign io_rresp_data = rresp_valid_q ? rdata : hold_q;
    end else begin : g_raw
      assign io_rresp_data = rdata;
    end
  endgenerate
endmodule

// File: tb/tb_sram_template_ext.sv
// tb_sram_template_ext: scoreboard bench for the default build plus a 256-set no-sweep build
module tb_sram_template_ext;
  localparam int SETS  = 64;
  localparam int WAYS  = 8;
  localparam int WIDTH = 6;
  localparam int DW    = WAYS * WIDTH;
  localparam logic [79:0] D2_HI = 80'hABCDE_12345_6789A_BCDEF;
  localparam logic [79:0] D2_LO = 80'h13579_2468A_FEDCB_A9876;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  logic          rreq_valid, rreq_ready, rresp_valid, wreq_valid, wreq_ready, init_done;
  logic [5:0]    rset, wset;
  logic [DW-1:0] rresp_data, wdata;
  logic [7:0]    wmask;
  logic          r2_valid, r2_ready, v2, w2_valid, w2_ready, done2;
  logic [7:0]    r2_set, w2_set;
  logic [79:0]   d2, w2_data;
  logic [3:0]    w2_mask;
  int checks = 0;
  int failures = 0;
  int rd_fires = 0;
  int wr_fires = 0;
  logic [DW-1:0] model [SETS];
  logic [DW-1:0] exp_q [$];
  sram_template_ext dut (
    .clock(clock), .reset_n(reset_n),
    .io_rreq_valid(rreq_valid), .io_rreq_ready(rreq_ready), .io_rreq_bits_setIdx(rset),
    .io_rresp_valid(rresp_valid), .io_rresp_data(rresp_data),
    .io_wreq_valid(wreq_valid), .io_wreq_ready(wreq_ready), .io_wreq_bits_setIdx(wset),
    .io_wreq_bits_data(wdata), .io_wreq_bits_waymask(wmask), .io_init_done(init_done)
  );
  sram_template_ext #(.SETS(256), .WAYS(4), .WIDTH(20), .HOLD_READ(1), .SHOULD_RESET(0)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .io_rreq_valid(r2_valid), .io_rreq_ready(r2_ready), .io_rreq_bits_setIdx(r2_set),
    .io_rresp_valid(v2), .io_rresp_data(d2),
    .io_wreq_valid(w2_valid), .io_wreq_ready(w2_ready), .io_wreq_bits_setIdx(w2_set),
    .io_wreq_bits_data(w2_data), .io_wreq_bits_waymask(w2_mask), .io_init_done(done2)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  // Scoreboard: model follows accepted writes, expected data queued on accepted reads
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      for (int i = 0; i < SETS; i++) model[i] <= '0;
    end else begin
      if (rresp_valid) begin
        if (exp_q.size() == 0) check("spurious_resp", 128'(1), 128'(0));
        else check("rdata", 128'(rresp_data), 128'(exp_q.pop_front()));
      end
      if (rreq_valid && rreq_ready) begin
        exp_q.push_back(model[rset]);
        rd_fires <= rd_fires + 1;
      end
      if (wreq_valid && wreq_ready) begin
        for (int i = 0; i < WAYS; i++)
          if (wmask[i]) model[wset][i*WIDTH +: WIDTH] <= wdata[i*WIDTH +: WIDTH];
        wr_fires <= wr_fires + 1;
      end
    end
  end
  task automatic rd(input logic [5:0] s);
    int n0 = rd_fires;
    int n = 0;
    rreq_valid = 1'b1;
    rset = s;
    while (rd_fires == n0 && n < 50) begin tick; n++; end
    rreq_valid = 1'b0;
    check("rd_accept", 128'(rd_fires != n0), 128'(1));
  endtask
  task automatic wr(input logic [5:0] s, input logic [DW-1:0] d, input logic [7:0] m);
    int n0 = wr_fires;
    int n = 0;
    wreq_valid = 1'b1;
    wset = s;
    wdata = d;
    wmask = m;
    while (wr_fires == n0 && n < 50) begin tick; n++; end
    wreq_valid = 1'b0;
    check("wr_accept", 128'(wr_fires != n0), 128'(1));
  endtask
  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin tick; n++; end
    check("drain", 128'(exp_q.size()), 128'(0));
  endtask
  task automatic sweep_check(input string tag);
    int n = 0;
    bit bad = 0;
    while (!init_done && n < 200) begin
      if (rreq_ready || wreq_ready) bad = 1;
      tick;
      n++;
    end
    check(tag, 128'(n), 128'(SETS));
    check("ready_in_init", 128'(bad), 128'(0));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [DW-1:0] d, old;
    logic [63:0] r;
    int n0, w0;
    bit d2_at1;
    rreq_valid = 0; rset = 0; wreq_valid = 0; wset = 0; wdata = 0; wmask = 0;
    r2_valid = 0; r2_set = 0; w2_valid = 0; w2_set = 0; w2_data = 0; w2_mask = 0;
    tick; tick;
    check("rst_done", 128'(init_done), 128'(0));
    check("rst_rready", 128'(rreq_ready), 128'(0));
    check("rst_wready", 128'(wreq_ready), 128'(0));
    check("rst_valid", 128'(rresp_valid), 128'(0));
    check("rst_data", 128'(rresp_data), 128'(0));
    check("rst2_rready", 128'(r2_ready), 128'(0));
    check("rst2_wready", 128'(w2_ready), 128'(0));
    reset_n = 1'b1;
    #1;
    check("done2_pre", 128'(done2), 128'(0));
    rreq_valid = 1'b1;
    rset = 6'd17;
    tick;
    d2_at1 = done2;
    check("done2_1cyc", 128'(d2_at1), 128'(1));
    begin
      int n = 1;
      bit bad = 0;
      while (!init_done && n < 200) begin
        if (rreq_ready || wreq_ready) bad = 1;
        tick;
        n++;
      end
      check("sweep_len", 128'(n), 128'(SETS));
      check("ready_in_init", 128'(bad), 128'(0));
    end
    rd(6'd17);
    drain;
    check("set17_zero", 128'(rresp_data), 128'(0));
    // 256-set build: last index round trip, no aliasing with set 0
    w2_valid = 1; w2_set = 8'hFF; w2_data = D2_HI; w2_mask = 4'hF;
    #1 check("w2_ready", 128'(w2_ready), 128'(1));
    tick;
    w2_set = 8'h00; w2_data = D2_LO;
    tick;
    w2_valid = 0; r2_valid = 1; r2_set = 8'hFF;
    #1 check("r2_ready", 128'(r2_ready), 128'(1));
    tick;
    r2_valid = 0;
    check("v2_pulse", 128'(v2), 128'(1));
    check("d2_set255", 128'(d2), 128'(D2_HI));
    tick;
    check("v2_low", 128'(v2), 128'(0));
    r2_valid = 1; r2_set = 8'h00;
    tick;
    r2_valid = 0;
    check("d2_set0", 128'(d2), 128'(D2_LO));
    // Masked write: only ways 0 and 2 take data
    d = {8{6'h3F}};
    d[5:0] = 6'h2A;
    d[17:12] = 6'h15;
    wr(6'd5, d, 8'h05);
    rd(6'd5);
    drain;
    check("pulse_1cyc", 128'(rresp_valid), 128'(0));
    check("wr5_const", 128'(rresp_data), 128'(48'h1502A));
    // Simultaneous read and write: write wins, read follows next cycle
    r = {$urandom(), $urandom()};
    wreq_valid = 1; wset = 6'd9; wdata = r[DW-1:0]; wmask = 8'hFF;
    rreq_valid = 1; rset = 6'd9;
    #1;
    check("conf_rready", 128'(rreq_ready), 128'(0));
    check("conf_wready", 128'(wreq_ready), 128'(1));
    n0 = rd_fires;
    w0 = wr_fires;
    tick;
    check("conf_wr", 128'(wr_fires - w0), 128'(1));
    check("conf_rd_blocked", 128'(rd_fires - n0), 128'(0));
    wreq_valid = 0;
    tick;
    check("conf_rd_next", 128'(rd_fires - n0), 128'(1));
    rreq_valid = 0;
    drain;
    check("conf_data", 128'(rresp_data), 128'(r[DW-1:0]));
    // Hold register keeps the last response across an intervening write
    rd(6'd5);
    drain;
    old = 48'h1502A;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        wreq_valid = 1; wset = 6'd5; wdata = {8{6'h11}}; wmask = 8'hFF;
      end else wreq_valid = 0;
      tick;
      check("hold", 128'(rresp_data), 128'(old));
    end
    rd(6'd5);
    drain;
    check("hold_new", 128'(rresp_data), 128'({8{6'h11}}));
    for (int s = 40; s < 64; s++) begin
      r = {$urandom(), $urandom()} | 64'h1;
      wr(6'(s), r[DW-1:0], 8'hFF);
    end
    rd(6'd63);
    drain;
    check("set63_written", 128'(rresp_data != 0), 128'(1));
    // Reset during a read drops the pending response
    rreq_valid = 1; rset = 6'd40;
    tick;
    rreq_valid = 0;
    check("pre_drop_valid", 128'(rresp_valid), 128'(1));
    reset_n = 0;
    #1;
    check("drop_valid", 128'(rresp_valid), 128'(0));
    tick; tick;
    reset_n = 1;
    repeat (30) tick;
    reset_n = 0;
    #1;
    check("midsweep_done", 128'(init_done), 128'(0));
    tick;
    check("midsweep_done2", 128'(init_done), 128'(0));
    reset_n = 1;
    sweep_check("resweep_len");
    for (int s = 40; s < 64; s++) rd(6'(s));
    drain;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_template_ext.md
Name: sram_template_ext

Overview:
- Parametrised single-port set-associative SRAM wrapper, next generation of the fixed 64-set, 8-way, 6-bit template.
- Used by predictor and cache metadata arrays in the frontend and memory block.
- Adds over the previous generation:
  - post-reset zero-initialisation sweep;
  - ready/valid back-pressure;
  - a read-response valid;
  - optional hold-read output register.

Parameters:
- SETS, 64, number of sets (power of two, ≥2).
- WAYS, 8, ways per set.
- WIDTH, 6, bits per way entry.
- HOLD_READ, 1, 1 = read data held in a register until the next read; 0 = raw array output.
- SHOULD_RESET, 1, 1 = zero all entries after reset; 0 = no sweep.
- Derived: IDXW = clog2(SETS).

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- io_rreq_valid  in  1  read request.
- io_rreq_ready  out  1  read accepted when valid&ready.
- io_rreq_bits_setIdx  in  IDXW  read set index.
- io_rresp_valid  out  1  read data valid (one-cycle pulse).
- io_rresp_data  out  WAYS*WIDTH  way i at bits [i*WIDTH +: WIDTH].
- io_wreq_valid  in  1  write request.
- io_wreq_ready  out  1  write accepted when valid&ready.
- io_wreq_bits_setIdx  in  IDXW  write set index.
- io_wreq_bits_data  in  WAYS*WIDTH  write data, same packing as io_rresp_data.
- io_wreq_bits_waymask  in  WAYS  per-way write enable.
- io_init_done  out  1  high once the array is usable.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - state=INIT when SHOULD_RESET=1, else IDLE;
  - init counter=0, io_rresp_valid=0, hold register=0, io_init_done=0.
- io_rreq_ready and io_wreq_ready are 0 while reset_n is low.
- FSM states:
  - INIT: each cycle, write all WAYS of set init_cnt with zeros (full waymask), then init_cnt++.
    - When init_cnt==SETS-1 that write completes; next state is IDLE and io_init_done=1 the following cycle.
    - Sweep length is exactly SETS cycles after reset release.
  - IDLE: normal operation; io_init_done stays 1 until reset.
  - With SHOULD_RESET=0, io_init_done rises on the first clock edge after reset release.
- Readiness:
  - INIT: io_wreq_ready=0 and io_rreq_ready=0.
  - IDLE: io_wreq_ready=1 and io_rreq_ready=~io_wreq_valid (write has priority on the single port).
- Array port:
  - en = write_fire | read_fire | INIT.
  - wmode = write_fire | INIT.
  - addr = INIT ? init_cnt : (io_wreq_valid ? wreq setIdx : rreq setIdx).
  - wmask = INIT ? all ones : waymask; wdata = INIT ? 0 : wreq data.
- Read latency is 1 cycle: io_rresp_valid=1 in the cycle after read_fire, otherwise 0.
- io_rresp_data with HOLD_READ=1:
  - Hold register loads the array output in each io_rresp_valid cycle and holds it otherwise.
  - The output is the hold register's value, except in the io_rresp_valid cycle, where the fresh array data is driven combinationally.
- io_rresp_data with HOLD_READ=0: raw array output; defined only when io_rresp_valid=1.
- Write then read of the same set in consecutive cycles returns the new data (write-before-read ordering, no bypass needed).
- Ways with waymask=0 keep their previous contents.
- Simultaneous rreq_valid and wreq_valid: write executes, read is not accepted (ready=0); the requester must hold the read.
- Reset asserted mid-sweep or mid-read: pending response dropped (io_rresp_valid=0), sweep restarts from set 0.
- Index arithmetic: init_cnt is IDXW bits wide, with an explicit terminal compare; no reliance on wrap-around.

Decomposition:
- Shared package sram_pkg: FSM state enum (INIT, IDLE) and the clog2 helper.
- One sub-module sram_array_1p:
  - behavioural single-port array, SETS×WAYS×WIDTH;
  - per-way write mask and registered read data;
  - port list RW0_addr/en/clk/wmode/wdata/wmask/rdata, packed into WAYS*WIDTH buses;
  - swappable for the foundry macro.
- Top level holds the FSM, readiness logic and hold register.

Test Plan:
- Reset release, SHOULD_RESET=1, SETS=64: io_init_done=0 and both readys=0 for 64 cycles, then io_init_done=1. Reading set 17 then returns all zeros.
- Write set 5, waymask=8'h05, data way0=6'h2A, way2=6'h15; next cycle read set 5. Response one cycle later: way0=2A, way2=15, other ways 0, io_rresp_valid pulse of exactly 1 cycle.
- rreq_valid and wreq_valid in the same cycle:
  - io_rreq_ready=0 and the write lands;
  - read held valid fires the next cycle and returns the written data.
- HOLD_READ=1: read set 5, then idle 10 cycles with a write to set 5 in between. io_rresp_data stays at the old read value until the next read response.
- Assert reset_n low at init_cnt=30:
  - io_init_done stays 0;
  - after release, the full 64-cycle sweep reruns;
  - entries previously written to sets 40–63 read back as 0.
- Parametrised build SETS=256, WAYS=4, WIDTH=20, SHOULD_RESET=0:
  - io_init_done=1 one cycle after reset;
  - write/read of set 255 (last index) round-trips correctly.
